// File: rtl/regfile_port_sched_pkg.sv
// rtl/regfile_port_sched_pkg.sv - shared constants and encodings for the regfile port scheduler
// Purpose: data/address widths, the x0 index, grant and issue-stage encodings.
// Ports: none (package).
package regfile_port_sched_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  // Who owns the regfile port in the cycle after the current one
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_RD   = 2'd1,
    GNT_W0   = 2'd2,
    GNT_W1   = 2'd3
  } gnt_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } issue_st_e;

endpackage

// File: rtl/regfile_port_sched_if.sv
// rtl/regfile_port_sched_if.sv - client and regfile bus bundle for the port scheduler
// Purpose: groups the read client, the two write clients, the read response and the
//          regfile drive/return signals.
// Modports:
//   slave  - scheduler view (takes requests, drives readies, response and regfile controls)
//   master - environment view (clients plus the regfile itself)
interface regfile_port_sched_if
  import regfile_port_sched_pkg::*;
#(
  parameter int P_DATA_W = DATA_W,
  parameter int P_ADDR_W = ADDR_W
);

  // read client
  logic                rq_valid;
  logic                rq_ready;
  logic [P_ADDR_W-1:0] rq_rs1;
  logic [P_ADDR_W-1:0] rq_rs2;
  // read response
  logic                rsp_valid;
  logic [P_DATA_W-1:0] rsp_rs1_data;
  logic [P_DATA_W-1:0] rsp_rs2_data;
  // write client 0 (ALU writeback)
  logic                w0_valid;
  logic                w0_ready;
  logic [P_ADDR_W-1:0] w0_rd;
  logic [P_DATA_W-1:0] w0_data;
  // write client 1 (load return)
  logic                w1_valid;
  logic                w1_ready;
  logic [P_ADDR_W-1:0] w1_rd;
  logic [P_DATA_W-1:0] w1_data;
  // regfile port
  logic                rf_read;
  logic [P_ADDR_W-1:0] rf_rd;
  logic [P_ADDR_W-1:0] rf_rs1;
  logic [P_ADDR_W-1:0] rf_rs2;
  logic [P_DATA_W-1:0] rf_data_in;
  logic [P_DATA_W-1:0] rf_rs1_out;
  logic [P_DATA_W-1:0] rf_rs2_out;

  modport slave (
    input  rq_valid, rq_rs1, rq_rs2,
    output rq_ready,
    output rsp_valid, rsp_rs1_data, rsp_rs2_data,
    input  w0_valid, w0_rd, w0_data,
    output w0_ready,
    input  w1_valid, w1_rd, w1_data,
    output w1_ready,
    output rf_read, rf_rd, rf_rs1, rf_rs2, rf_data_in,
    input  rf_rs1_out, rf_rs2_out
  );

  modport master (
    output rq_valid, rq_rs1, rq_rs2,
    input  rq_ready,
    input  rsp_valid, rsp_rs1_data, rsp_rs2_data,
    output w0_valid, w0_rd, w0_data,
    input  w0_ready,
    output w1_valid, w1_rd, w1_data,
    input  w1_ready,
    input  rf_read, rf_rd, rf_rs1, rf_rs2, rf_data_in,
    output rf_rs1_out, rf_rs2_out
  );

endinterface

// File: rtl/regfile_port_sched_rf_wr_rr_arb.sv
// rtl/regfile_port_sched_rf_wr_rr_arb.sv - two-way round-robin between the write clients
// Purpose: picks W0 or W1 when the top decides a write owns the next slot.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_req[1:0]     write requests (bit0 = W0, bit1 = W1)
//   i_grant_en     a write slot is available this cycle
//   o_gnt[1:0]     one-hot grant, zero when i_grant_en is low
module rf_wr_rr_arb (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_grant_en,
  output logic [1:0] o_gnt
);

  // 1 = W1 won the most recent tie; reset to W1 so the first tie goes to W0
  logic r_rr_last;
  logic [1:0] w_sel;

  always_comb begin
    w_sel = 2'b00;
    case (i_req)
      2'b01:   w_sel = 2'b01;
      2'b10:   w_sel = 2'b10;
      2'b11:   w_sel = r_rr_last ? 2'b01 : 2'b10;
      default: w_sel = 2'b00;
    endcase
  end

  assign o_gnt = i_grant_en ? w_sel : 2'b00;

  // Only a contested grant moves the pointer; an uncontested grant says nothing about fairness
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rr_last <= 1'b1;
    end else if (i_grant_en && (i_req == 2'b11)) begin
      r_rr_last <= w_sel[1];
    end
  end

endmodule

// File: rtl/regfile_port_sched.sv
// rtl/regfile_port_sched.sv - single-mode 32x32 regfile port scheduler (1 reader, 2 writers)
// Purpose: arbitrates one read client against two write clients for a regfile that either
//          reads two ports or writes one port per cycle, through one registered issue stage.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   io (slave)     rq_* read request, rsp_* read response (2 cycles after accept),
//                  w0_*/w1_* write requests, rf_* regfile controls and read data
module regfile_port_sched
  import regfile_port_sched_pkg::*;
#(
  parameter int P_DATA_W       = DATA_W,
  parameter int P_ADDR_W       = ADDR_W,
  parameter int P_STARVE_LIMIT = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  regfile_port_sched_if.slave  io
);

  localparam logic [3:0] STARVE_MAX = 4'(P_STARVE_LIMIT);

  logic [3:0]          r_starve_cnt;
  issue_st_e           r_state;
  logic                r_rf_read;
  logic [P_ADDR_W-1:0] r_rf_rd;
  logic [P_ADDR_W-1:0] r_rf_rs1;
  logic [P_ADDR_W-1:0] r_rf_rs2;
  logic [P_DATA_W-1:0] r_rf_data_in;
  logic                r_rsp_valid;
  logic [P_DATA_W-1:0] r_rsp_rs1_data;
  logic [P_DATA_W-1:0] r_rsp_rs2_data;

  logic                w_any_wr;
  logic                w_rd_gnt;
  logic                w_wr_en;
  logic [1:0]          w_arb_gnt;
  gnt_e                w_gnt;
  logic [P_ADDR_W-1:0] w_wr_rd;
  logic [P_DATA_W-1:0] w_wr_data;

  // A read wins unless writes have waited through STARVE_MAX read grants
  always_comb begin
    w_any_wr = io.w0_valid | io.w1_valid;
    w_rd_gnt = io.rq_valid & (~w_any_wr | (r_starve_cnt < STARVE_MAX));
    w_wr_en  = w_any_wr & ~w_rd_gnt;
  end

  rf_wr_rr_arb u_wr_arb (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_req      ({io.w1_valid, io.w0_valid}),
    .i_grant_en (w_wr_en),
    .o_gnt      (w_arb_gnt)
  );

  always_comb begin
    w_gnt = GNT_NONE;
    if (w_rd_gnt)          w_gnt = GNT_RD;
    else if (w_arb_gnt[0]) w_gnt = GNT_W0;
    else if (w_arb_gnt[1]) w_gnt = GNT_W1;
  end

  assign w_wr_rd   = w_arb_gnt[1] ? io.w1_rd   : io.w0_rd;
  assign w_wr_data = w_arb_gnt[1] ? io.w1_data : io.w0_data;

  assign io.rq_ready = w_rd_gnt;
  assign io.w0_ready = w_arb_gnt[0];
  assign io.w1_ready = w_arb_gnt[1];

  // Counts reads granted over a waiting write; any write grant (x0 included) clears it
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_starve_cnt <= 4'd0;
    end else if (w_wr_en) begin
      r_starve_cnt <= 4'd0;
    end else if (w_rd_gnt && w_any_wr) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

  // Issue stage and response capture. Regfile data is sampled at the end of the RD cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= ST_IDLE;
      r_rf_read      <= 1'b1;
      r_rf_rd        <= '0;
      r_rf_rs1       <= '0;
      r_rf_rs2       <= '0;
      r_rf_data_in   <= '0;
      r_rsp_valid    <= 1'b0;
      r_rsp_rs1_data <= '0;
      r_rsp_rs2_data <= '0;
    end else begin
      r_rsp_valid <= (r_state == ST_RD);
      if (r_state == ST_RD) begin
        r_rsp_rs1_data <= io.rf_rs1_out;
        r_rsp_rs2_data <= io.rf_rs2_out;
      end

      r_state      <= ST_IDLE;
      r_rf_read    <= 1'b1;
      r_rf_rd      <= '0;
      r_rf_rs1     <= '0;
      r_rf_rs2     <= '0;
      r_rf_data_in <= '0;
      case (w_gnt)
        GNT_RD: begin
          r_state  <= ST_RD;
          r_rf_rs1 <= io.rq_rs1;
          r_rf_rs2 <= io.rq_rs2;
        end
        GNT_W0, GNT_W1: begin
          // x0 writes are accepted but swallowed here: the slot stays idle
          if (w_wr_rd != REG_ZERO) begin
            r_state      <= ST_WR;
            r_rf_read    <= 1'b0;
            r_rf_rd      <= w_wr_rd;
            r_rf_data_in <= w_wr_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign io.rf_read      = r_rf_read;
  assign io.rf_rd        = r_rf_rd;
  assign io.rf_rs1       = r_rf_rs1;
  assign io.rf_rs2       = r_rf_rs2;
  assign io.rf_data_in   = r_rf_data_in;
  assign io.rsp_valid    = r_rsp_valid;
  assign io.rsp_rs1_data = r_rsp_rs1_data;
  assign io.rsp_rs2_data = r_rsp_rs2_data;

endmodule

// File: tb/tb_regfile_port_sched.sv
// tb/tb_regfile_port_sched.sv - directed self-checking bench for regfile_port_sched
module tb_regfile_port_sched;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   wr_issued;
  logic [31:0] mem [32];

  regfile_port_sched_if bus ();

  regfile_port_sched #(.P_STARVE_LIMIT(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Regfile model: combinational read, write committed at the end of a write cycle.
  // x0 is not special here, so any write to it would show up on a later read.
  assign bus.rf_rs1_out = mem[bus.rf_rs1];
  assign bus.rf_rs2_out = mem[bus.rf_rs2];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'd0;
    end else if (!bus.rf_read) begin
      mem[bus.rf_rd] <= bus.rf_data_in;
      wr_issued      <= wr_issued + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    wr_issued = 0;
    rst = 1'b1;
    bus.rq_valid = 0; bus.rq_rs1 = 0; bus.rq_rs2 = 0;
    bus.w0_valid = 0; bus.w0_rd = 0; bus.w0_data = 0;
    bus.w1_valid = 0; bus.w1_rd = 0; bus.w1_data = 0;

    // 1. reset then idle
    tick();
    check("rst_rf_read", 32'(bus.rf_read), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rf_rs1", 32'(bus.rf_rs1), 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_rf_read", 32'(bus.rf_read), 32'd1);
      check("idle_rf_rd", 32'(bus.rf_rd), 32'd0);
      check("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    end

    // 2. W0 x1=50, W1 x27=25, then read x1/x27
    bus.w0_valid = 1; bus.w0_rd = 5'd1; bus.w0_data = 32'd50;
    #1;
    check("t2_w0_ready", 32'(bus.w0_ready), 32'd1);
    check("t2_rq_ready", 32'(bus.rq_ready), 32'd0);
    tick();
    check("t2_wr_mode", 32'(bus.rf_read), 32'd0);
    check("t2_wr_rd", 32'(bus.rf_rd), 32'd1);
    check("t2_wr_data", bus.rf_data_in, 32'd50);
    bus.w0_valid = 0;
    bus.w1_valid = 1; bus.w1_rd = 5'd27; bus.w1_data = 32'd25;
    #1;
    check("t2_w1_ready", 32'(bus.w1_ready), 32'd1);
    tick();
    check("t2_wr1_rd", 32'(bus.rf_rd), 32'd27);
    bus.w1_valid = 0;
    bus.rq_valid = 1; bus.rq_rs1 = 5'd1; bus.rq_rs2 = 5'd27;
    #1;
    check("t2_rq_ready", 32'(bus.rq_ready), 32'd1);
    tick();
    check("t2_rd_mode", 32'(bus.rf_read), 32'd1);
    check("t2_rd_rs1", 32'(bus.rf_rs1), 32'd1);
    check("t2_rd_rs2", 32'(bus.rf_rs2), 32'd27);
    check("t2_rsp_early", 32'(bus.rsp_valid), 32'd0);
    bus.rq_valid = 0;
    tick();
    check("t2_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("t2_rsp_rs1", bus.rsp_rs1_data, 32'd50);
    check("t2_rsp_rs2", bus.rsp_rs2_data, 32'd25);
    tick();
    check("t2_rsp_pulse", 32'(bus.rsp_valid), 32'd0);

    // 3. write contention and round-robin on ties
    bus.w0_valid = 1; bus.w0_rd = 5'd3; bus.w0_data = 32'd5;
    bus.w1_valid = 1; bus.w1_rd = 5'd4; bus.w1_data = 32'd6;
    #1;
    check("t3_tie1_w0", 32'(bus.w0_ready), 32'd1);
    check("t3_tie1_w1", 32'(bus.w1_ready), 32'd0);
    tick();
    check("t3_wr_rd3", 32'(bus.rf_rd), 32'd3);
    check("t3_wr_d5", bus.rf_data_in, 32'd5);
    bus.w0_valid = 0;
    #1;
    check("t3_w1_next", 32'(bus.w1_ready), 32'd1);
    tick();
    check("t3_wr_rd4", 32'(bus.rf_rd), 32'd4);
    check("t3_wr_d6", bus.rf_data_in, 32'd6);
    bus.w0_valid = 1; bus.w0_rd = 5'd5; bus.w0_data = 32'd7;
    bus.w1_valid = 1; bus.w1_rd = 5'd6; bus.w1_data = 32'd8;
    #1;
    check("t3_tie2_w1", 32'(bus.w1_ready), 32'd1);
    check("t3_tie2_w0", 32'(bus.w0_ready), 32'd0);
    tick();
    check("t3_wr_rd6", 32'(bus.rf_rd), 32'd6);
    bus.w1_rd = 5'd7; bus.w1_data = 32'd9;
    #1;
    check("t3_tie3_w0", 32'(bus.w0_ready), 32'd1);
    check("t3_tie3_w1", 32'(bus.w1_ready), 32'd0);
    tick();
    check("t3_wr_rd5", 32'(bus.rf_rd), 32'd5);
    bus.w0_valid = 0;
    #1;
    check("t3_w1_last", 32'(bus.w1_ready), 32'd1);
    tick();
    check("t3_wr_rd7", 32'(bus.rf_rd), 32'd7);
    bus.w1_valid = 0;
    tick();

    // 4. starvation: four reads, then the waiting write, then reads resume
    bus.rq_valid = 1; bus.rq_rs1 = 5'd3; bus.rq_rs2 = 5'd4;
    bus.w0_valid = 1; bus.w0_rd = 5'd8; bus.w0_data = 32'd11;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t4_rd_gnt", 32'(bus.rq_ready), 32'd1);
      check("t4_w0_wait", 32'(bus.w0_ready), 32'd0);
      if (i >= 2) begin
        check("t4_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("t4_rsp_rs1", bus.rsp_rs1_data, 32'd5);
        check("t4_rsp_rs2", bus.rsp_rs2_data, 32'd6);
      end
      tick();
    end
    #1;
    check("t4_forced_rq", 32'(bus.rq_ready), 32'd0);
    check("t4_forced_w0", 32'(bus.w0_ready), 32'd1);
    check("t4_rsp_i2", 32'(bus.rsp_valid), 32'd1);
    tick();
    bus.w0_valid = 0;
    #1;
    check("t4_resume", 32'(bus.rq_ready), 32'd1);
    check("t4_wr_mode", 32'(bus.rf_read), 32'd0);
    check("t4_wr_rd8", 32'(bus.rf_rd), 32'd8);
    check("t4_rsp_i3", 32'(bus.rsp_valid), 32'd1);
    tick();
    bus.rq_valid = 0;
    check("t4_rsp_gap", 32'(bus.rsp_valid), 32'd0);
    tick();
    check("t4_rsp_resume", 32'(bus.rsp_valid), 32'd1);
    tick();

    // 5. write to x0 is accepted but never issued
    bus.w1_valid = 1; bus.w1_rd = 5'd0; bus.w1_data = 32'hDEAD;
    #1;
    check("t5_w1_ready", 32'(bus.w1_ready), 32'd1);
    tick();
    check("t5_no_wr", 32'(bus.rf_read), 32'd1);
    check("t5_rf_rd", 32'(bus.rf_rd), 32'd0);
    bus.w1_valid = 0;
    bus.rq_valid = 1; bus.rq_rs1 = 5'd0; bus.rq_rs2 = 5'd8;
    #1;
    check("t5_rq_ready", 32'(bus.rq_ready), 32'd1);
    tick();
    bus.rq_valid = 0;
    tick();
    check("t5_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("t5_x0_read", bus.rsp_rs1_data, 32'd0);
    check("t5_x8_read", bus.rsp_rs2_data, 32'd11);
    tick();

    // 6. reset mid-read drops the response and restores round-robin
    bus.rq_valid = 1; bus.rq_rs1 = 5'd1; bus.rq_rs2 = 5'd3;
    #1;
    check("t6_rq_ready", 32'(bus.rq_ready), 32'd1);
    tick();
    bus.rq_valid = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rsp_drop", 32'(bus.rsp_valid), 32'd0);
    check("t6_idle_mode", 32'(bus.rf_read), 32'd1);
    check("t6_idle_rs1", 32'(bus.rf_rs1), 32'd0);
    tick();
    check("t6_no_replay", 32'(bus.rsp_valid), 32'd0);
    bus.w0_valid = 1; bus.w0_rd = 5'd9;  bus.w0_data = 32'd1;
    bus.w1_valid = 1; bus.w1_rd = 5'd10; bus.w1_data = 32'd2;
    #1;
    check("t6_tie_w0", 32'(bus.w0_ready), 32'd1);
    check("t6_tie_w1", 32'(bus.w1_ready), 32'd0);
    tick();
    check("t6_wr_rd9", 32'(bus.rf_rd), 32'd9);
    bus.w0_valid = 0;
    bus.w1_valid = 0;
    tick();
    tick();

    // 2 + 5 + 1 + 1 real writes; x0 and idle cycles must add nothing
    check("total_writes", 32'(wr_issued), 32'd9);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
